// File: rtl/ifc_seq_ctrl_if.sv
// ifc_seq_ctrl_if -- bundle of every non-clock signal of ifc_seq_ctrl:
// host request, host source/sink byte streams, status, and the dut
// cfg/len/din/dout ports.
// master : the sequencer's view (drives handshakes toward host and dut).
// slave  : the environment's view (host plus dut model).
interface ifc_seq_ctrl_if;
   // host request
   logic        req_valid;
   logic [7:0]  req_len;
   logic [31:0] req_cfg;
   logic        req_ready;
   // host source bytes
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   // host sink bytes
   logic        m_valid;
   logic [7:0]  m_data;
   logic        m_ready;
   // status
   logic        busy;
   logic        done;
   logic        err;
   // dut cfg port
   logic [7:0]  cfg_address;
   logic [31:0] cfg_data_in;
   logic        cfg_op;
   logic        cfg_en;
   logic [31:0] cfg_data_out;
   logic        cfg_rdy;
   // dut len port
   logic [7:0]  len_value;
   logic        len_en;
   logic        len_rdy;
   // dut data ports
   logic [7:0]  din_value;
   logic        din_en;
   logic        din_rdy;
   logic        dout_en;
   logic [7:0]  dout_value;
   logic        dout_rdy;

   modport master (
      input  req_valid, req_len, req_cfg,
      input  s_valid, s_data,
      input  m_ready,
      input  cfg_data_out, cfg_rdy,
      input  len_rdy,
      input  din_rdy, dout_value, dout_rdy,
      output req_ready, s_ready, m_valid, m_data,
      output busy, done, err,
      output cfg_address, cfg_data_in, cfg_op, cfg_en,
      output len_value, len_en,
      output din_value, din_en, dout_en
   );

   modport slave (
      output req_valid, req_len, req_cfg,
      output s_valid, s_data,
      output m_ready,
      output cfg_data_out, cfg_rdy,
      output len_rdy,
      output din_rdy, dout_value, dout_rdy,
      input  req_ready, s_ready, m_valid, m_data,
      input  busy, done, err,
      input  cfg_address, cfg_data_in, cfg_op, cfg_en,
      input  len_value, len_en,
      input  din_value, din_en, dout_en
   );
endinterface

// File: rtl/ifc_seq_ctrl.sv
// ifc_seq_ctrl -- sequences one host request into a dut transaction:
// write the config register, optionally read it back, program the length,
// then stream len bytes into the dut and len bytes out of it, and pulse done.
// Optional feature macro: SEQ_READBACK_EN enables the CFG_RD readback state
// and the sticky err flag; without it err is tied low and CFG_RD is never
// entered.
module ifc_seq_ctrl #(
   parameter logic [7:0] CFG_ADDR = 8'h00,
   parameter logic       RB_OP    = 1'b0
) (
   input  logic           i_clk,
   input  logic           i_rst,
   ifc_seq_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CFG_WR = 3'd1,
      S_CFG_RD = 3'd2,
      S_LEN    = 3'd3,
      S_STREAM = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [7:0]  r_len;
   logic [31:0] r_cfg;
   logic [7:0]  r_in_cnt;
   logic [7:0]  r_out_cnt;

   logic        w_accept;
   logic        w_in_full;
   logic        w_out_full;
   logic        w_din_fire;
   logic        w_dout_fire;
   logic        w_enter_len;

`ifdef SEQ_READBACK_EN
   logic        r_err;
   logic        w_rb_match;
`endif

   // Handshake and progress terms shared by the FSM and the datapath.
   // Counters stop at len, so len = 255 never wraps them.
   assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
   assign w_in_full   = (r_in_cnt  == r_len);
   assign w_out_full  = (r_out_cnt == r_len);
   assign w_din_fire  = (r_state == S_STREAM) && bus.s_valid && bus.din_rdy && !w_in_full;
   assign w_dout_fire = (r_state == S_STREAM) && bus.dout_rdy && !w_out_full && bus.m_ready;
   assign w_enter_len = (w_state_next == S_LEN) && (r_state != S_LEN);

`ifdef SEQ_READBACK_EN
   assign w_rb_match  = (bus.cfg_data_out == r_cfg);
`endif

   // State register: synchronous reset returns to IDLE, aborting any transfer.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: each dut phase advances only on its own enable.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.req_valid) begin
               w_state_next = S_CFG_WR;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_CFG_WR: begin
            if (bus.cfg_rdy) begin
`ifdef SEQ_READBACK_EN
               w_state_next = S_CFG_RD;
`else
               w_state_next = S_LEN;
`endif
            end else begin
               w_state_next = S_CFG_WR;
            end
         end
         S_CFG_RD: begin
`ifdef SEQ_READBACK_EN
            if (bus.cfg_rdy) begin
               if (w_rb_match) begin
                  w_state_next = S_LEN;
               end else begin
                  w_state_next = S_DONE;
               end
            end else begin
               w_state_next = S_CFG_RD;
            end
`else
            w_state_next = S_IDLE;
`endif
         end
         S_LEN: begin
            if (bus.len_rdy) begin
               if (r_len == 8'd0) begin
                  w_state_next = S_DONE;
               end else begin
                  w_state_next = S_STREAM;
               end
            end else begin
               w_state_next = S_LEN;
            end
         end
         S_STREAM: begin
            if (w_in_full && w_out_full) begin
               w_state_next = S_DONE;
            end else begin
               w_state_next = S_STREAM;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Output decode: every dut enable is gated by its rdy and its owning state.
   always_comb begin
      bus.req_ready   = 1'b0;
      bus.s_ready     = 1'b0;
      bus.m_valid     = 1'b0;
      bus.m_data      = 8'h00;
      bus.busy        = 1'b0;
      bus.done        = 1'b0;
      bus.cfg_address = 8'h00;
      bus.cfg_data_in = 32'h0000_0000;
      bus.cfg_op      = 1'b0;
      bus.cfg_en      = 1'b0;
      bus.len_value   = 8'h00;
      bus.len_en      = 1'b0;
      bus.din_value   = 8'h00;
      bus.din_en      = 1'b0;
      bus.dout_en     = 1'b0;
      case (r_state)
         S_IDLE: begin
            bus.req_ready = 1'b1;
         end
         S_CFG_WR: begin
            bus.busy        = 1'b1;
            bus.cfg_en      = bus.cfg_rdy;
            bus.cfg_address = CFG_ADDR;
            bus.cfg_data_in = r_cfg;
            bus.cfg_op      = ~RB_OP;
         end
         S_CFG_RD: begin
            bus.busy        = 1'b1;
`ifdef SEQ_READBACK_EN
            bus.cfg_en      = bus.cfg_rdy;
            bus.cfg_address = CFG_ADDR;
            bus.cfg_op      = RB_OP;
`endif
         end
         S_LEN: begin
            bus.busy      = 1'b1;
            bus.len_en    = bus.len_rdy;
            bus.len_value = r_len;
         end
         S_STREAM: begin
            bus.busy      = 1'b1;
            bus.din_en    = w_din_fire;
            bus.s_ready   = w_din_fire;
            bus.din_value = bus.s_data;
            bus.m_valid   = bus.dout_rdy && !w_out_full;
            bus.m_data    = bus.dout_value;
            bus.dout_en   = w_dout_fire;
         end
         S_DONE: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
         end
         default: begin
            bus.busy = 1'b0;
         end
      endcase
`ifdef SEQ_READBACK_EN
      bus.err = r_err;
`else
      bus.err = 1'b0;
`endif
   end

   // Request latch and byte counters; counters restart on every entry to LEN
   // and the two stream sides advance independently.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_len     <= 8'd0;
         r_cfg     <= 32'h0000_0000;
         r_in_cnt  <= 8'd0;
         r_out_cnt <= 8'd0;
      end else begin
         if (w_accept) begin
            r_len <= bus.req_len;
            r_cfg <= bus.req_cfg;
         end else begin
            r_len <= r_len;
            r_cfg <= r_cfg;
         end
         if (w_enter_len) begin
            r_in_cnt  <= 8'd0;
            r_out_cnt <= 8'd0;
         end else begin
            if (w_din_fire) begin
               r_in_cnt <= r_in_cnt + 8'd1;
            end else begin
               r_in_cnt <= r_in_cnt;
            end
            if (w_dout_fire) begin
               r_out_cnt <= r_out_cnt + 8'd1;
            end else begin
               r_out_cnt <= r_out_cnt;
            end
         end
      end
   end

`ifdef SEQ_READBACK_EN
   // Sticky readback error: set on a mismatched read, cleared by the next request.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= 1'b0;
      end else if ((r_state == S_CFG_RD) && bus.cfg_rdy && !w_rb_match) begin
         r_err <= 1'b1;
      end else begin
         r_err <= r_err;
      end
   end
`endif

endmodule

// File: tb/tb_ifc_seq_ctrl.sv
// tb_ifc_seq_ctrl -- directed bench for ifc_seq_ctrl. The bench plays both
// host and dut: the dut model remembers the last config write and returns it
// on readback. A negedge monitor logs every enable and its data.
module tb_ifc_seq_ctrl;

   localparam logic [7:0] TB_ADDR = 8'h3C;
   localparam logic       TB_RB   = 1'b0;
`ifdef SEQ_READBACK_EN
   localparam int EXP_RD = 1;
`else
   localparam int EXP_RD = 0;
`endif

   logic clk;
   logic rst;

   ifc_seq_ctrl_if bus ();

   ifc_seq_ctrl #(
      .CFG_ADDR (TB_ADDR),
      .RB_OP    (TB_RB)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // bookkeeping written only by the monitor
   int          cyc_n     = 0;
   int          wr_cnt    = 0;
   int          rd_cnt    = 0;
   int          len_cnt   = 0;
   int          din_cnt   = 0;
   int          dout_cnt  = 0;
   int          done_cnt  = 0;
   int          viol_cnt  = 0;
   int          len_cyc   = 0;
   int          done_cyc  = 0;
   logic [31:0] last_cfg  = 32'h0;
   logic [7:0]  last_addr = 8'h0;
   logic [7:0]  last_len  = 8'h0;
   logic [31:0] model_reg = 32'h0;
   logic [7:0]  din_log  [1024];
   logic [7:0]  dout_log [1024];

   // written only by the main stimulus process
   logic        force_zero;
   int          n_cmp = 0;
   int          n_err = 0;
   int          b_wr, b_rd, b_len, b_din, b_dout, b_done;

   // host source and dut output data follow the transfer counts
   assign bus.s_data       = 8'hA0 + din_cnt[7:0];
   assign bus.dout_value   = 8'h50 + dout_cnt[7:0];
   assign bus.cfg_data_out = force_zero ? 32'h0 : model_reg;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // monitor: log enables mid-cycle, count rule violations
   always @(negedge clk) begin
      cyc_n = cyc_n + 1;
      if (bus.cfg_en) begin
         if (!bus.cfg_rdy) viol_cnt = viol_cnt + 1;
         if (bus.cfg_op == ~TB_RB) begin
            wr_cnt    = wr_cnt + 1;
            last_cfg  = bus.cfg_data_in;
            last_addr = bus.cfg_address;
            model_reg = bus.cfg_data_in;
         end else begin
            rd_cnt = rd_cnt + 1;
         end
      end
      if (bus.len_en) begin
         if (!bus.len_rdy) viol_cnt = viol_cnt + 1;
         len_cnt  = len_cnt + 1;
         last_len = bus.len_value;
         len_cyc  = cyc_n;
      end
      if (bus.din_en) begin
         if (!(bus.din_rdy && bus.s_valid && bus.s_ready)) viol_cnt = viol_cnt + 1;
         din_log[din_cnt % 1024] = bus.din_value;
         din_cnt = din_cnt + 1;
      end
      if (bus.dout_en) begin
         if (!(bus.dout_rdy && bus.m_ready && bus.m_valid)) viol_cnt = viol_cnt + 1;
         dout_log[dout_cnt % 1024] = bus.m_data;
         dout_cnt = dout_cnt + 1;
      end
      if (bus.done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc_n;
      end
      if (bus.busy == bus.req_ready) viol_cnt = viol_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_wr = wr_cnt; b_rd = rd_cnt; b_len = len_cnt;
      b_din = din_cnt; b_dout = dout_cnt; b_done = done_cnt;
   endtask

   // per-cycle environment pattern; mode 1 stalls cfg and din, toggles m_ready
   task automatic apply_mode(input int mode, input int k);
      if (mode == 1) begin
         bus.cfg_rdy = (k >= 2);
         bus.din_rdy = (k >= 9);
         bus.m_ready = k[0];
      end else begin
         bus.cfg_rdy = 1'b1;
         bus.din_rdy = 1'b1;
         bus.m_ready = 1'b1;
      end
   endtask

   // issue one request and wait (bounded) for its done pulse
   task automatic run_req(input logic [7:0] len, input logic [31:0] cfg,
                          input int mode, output bit ok);
      ok = 1'b0;
      snap();
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_len   = len;
      bus.req_cfg   = cfg;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      for (int k = 0; k < 700; k++) begin
         apply_mode(mode, k);
         @(posedge clk); #1;
         if (done_cnt != b_done) begin
            ok = 1'b1;
            break;
         end
      end
      apply_mode(0, 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_bytes(input string tag, input int n);
      logic [7:0] e;
      for (int i = 0; i < n; i++) begin
         e = 8'hA0 + 8'(b_din + i);
         check_eq({tag, "_din_byte"}, {24'h0, din_log[(b_din + i) % 1024]}, {24'h0, e});
         e = 8'h50 + 8'(b_dout + i);
         check_eq({tag, "_dout_byte"}, {24'h0, dout_log[(b_dout + i) % 1024]}, {24'h0, e});
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      bit hit;
      rst            = 1'b1;
      force_zero     = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_len    = 8'h00;
      bus.req_cfg    = 32'h0;
      bus.s_valid    = 1'b1;
      bus.m_ready    = 1'b1;
      bus.cfg_rdy    = 1'b1;
      bus.len_rdy    = 1'b1;
      bus.din_rdy    = 1'b1;
      bus.dout_rdy   = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      check_eq("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
      check_eq("rst_busy", {31'h0, bus.busy}, 32'h0);
      check_eq("rst_err", {31'h0, bus.err}, 32'h0);
      check_eq("rst_enables", {25'h0, bus.cfg_en, bus.len_en, bus.din_en, bus.dout_en,
                               bus.m_valid, bus.s_ready, bus.done}, 32'h0);
      check_eq("rst_cfg_addr", {24'h0, bus.cfg_address}, 32'h0);

      // basic transfer len=4
      run_req(8'd4, 32'hDEADBEEF, 0, ok);
      check_eq("l4_done_seen", {31'h0, ok}, 32'h1);
      check_eq("l4_wr", wr_cnt - b_wr, 32'd1);
      check_eq("l4_cfg_data", last_cfg, 32'hDEADBEEF);
      check_eq("l4_cfg_addr", {24'h0, last_addr}, {24'h0, TB_ADDR});
      check_eq("l4_rd", rd_cnt - b_rd, EXP_RD);
      check_eq("l4_len", len_cnt - b_len, 32'd1);
      check_eq("l4_len_value", {24'h0, last_len}, 32'd4);
      check_eq("l4_din", din_cnt - b_din, 32'd4);
      check_eq("l4_dout", dout_cnt - b_dout, 32'd4);
      check_eq("l4_done", done_cnt - b_done, 32'd1);
      check_eq("l4_err", {31'h0, bus.err}, 32'h0);
      check_bytes("l4", 4);

      // zero length
      run_req(8'd0, 32'h0000_1111, 0, ok);
      check_eq("l0_done_seen", {31'h0, ok}, 32'h1);
      check_eq("l0_wr", wr_cnt - b_wr, 32'd1);
      check_eq("l0_len", len_cnt - b_len, 32'd1);
      check_eq("l0_din", din_cnt - b_din, 32'd0);
      check_eq("l0_dout", dout_cnt - b_dout, 32'd0);
      check_eq("l0_done", done_cnt - b_done, 32'd1);
      check_eq("l0_done_latency", done_cyc - len_cyc, 32'd1);

      // stalls: cfg_rdy late, din_rdy low, m_ready toggling
      run_req(8'd3, 32'h1234_5678, 1, ok);
      check_eq("l3_done_seen", {31'h0, ok}, 32'h1);
      check_eq("l3_cfg_data", last_cfg, 32'h1234_5678);
      check_eq("l3_din", din_cnt - b_din, 32'd3);
      check_eq("l3_dout", dout_cnt - b_dout, 32'd3);
      check_eq("l3_done", done_cnt - b_done, 32'd1);
      check_bytes("l3", 3);

      // reset in the middle of STREAM once two bytes have gone in
      snap();
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_len   = 8'd6;
      bus.req_cfg   = 32'hA5A5_0006;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (din_cnt - b_din == 2) begin
            hit = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check_eq("rs_reached_cnt2", {31'h0, hit}, 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rs_req_ready", {31'h0, bus.req_ready}, 32'h1);
      check_eq("rs_busy", {31'h0, bus.busy}, 32'h0);
      check_eq("rs_enables", {27'h0, bus.cfg_en, bus.len_en, bus.din_en, bus.dout_en,
                              bus.m_valid}, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("rs_no_done", done_cnt - b_done, 32'd0);

      run_req(8'd2, 32'h0BAD_CAFE, 0, ok);
      check_eq("rs2_done_seen", {31'h0, ok}, 32'h1);
      check_eq("rs2_din", din_cnt - b_din, 32'd2);
      check_eq("rs2_dout", dout_cnt - b_dout, 32'd2);
      check_eq("rs2_done", done_cnt - b_done, 32'd1);
      check_bytes("rs2", 2);

      // maximum length, both sides finish in the same cycle
      run_req(8'd255, 32'hFFFF_00FF, 0, ok);
      check_eq("l255_done_seen", {31'h0, ok}, 32'h1);
      check_eq("l255_din", din_cnt - b_din, 32'd255);
      check_eq("l255_dout", dout_cnt - b_dout, 32'd255);
      check_eq("l255_done", done_cnt - b_done, 32'd1);
      check_eq("l255_in_cnt", {24'h0, dut.r_in_cnt}, 32'd255);
      check_eq("l255_out_cnt", {24'h0, dut.r_out_cnt}, 32'd255);

`ifdef SEQ_READBACK_EN
      // readback mismatch
      force_zero = 1'b1;
      run_req(8'd5, 32'hCAFE_F00D, 0, ok);
      force_zero = 1'b0;
      check_eq("rb_done_seen", {31'h0, ok}, 32'h1);
      check_eq("rb_err", {31'h0, bus.err}, 32'h1);
      check_eq("rb_rd", rd_cnt - b_rd, 32'd1);
      check_eq("rb_len", len_cnt - b_len, 32'd0);
      check_eq("rb_din", din_cnt - b_din, 32'd0);
      check_eq("rb_dout", dout_cnt - b_dout, 32'd0);
      check_eq("rb_done", done_cnt - b_done, 32'd1);
      run_req(8'd1, 32'h0000_0001, 0, ok);
      check_eq("rb_clear_done_seen", {31'h0, ok}, 32'h1);
      check_eq("rb_err_cleared", {31'h0, bus.err}, 32'h0);
`else
      check_eq("final_err", {31'h0, bus.err}, 32'h0);
`endif

      check_eq("rule_violations", viol_cnt, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
